debug_ring_terminator: RTL and testbench



---
 rtl/debug_ring_terminator.sv | 164 ++++++++++++++++
 tb/tb_debug_ring_terminator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/debug_ring_terminator.sv
// debug_ring_terminator: closes the open end of a dual-ring debug chain.
//
// Purpose : flits leaving ring 0 are buffered and re-injected at the start of
//           ring 1 (second pass). Flits leaving ring 1 were never claimed; they
//           are swallowed, each dropped packet is counted (saturating) and the
//           destination ID of its first flit is kept for debug. Ring 0's chain
//           start is held idle.
// Latency : turnaround FIFO has one cycle from push to ring1_out; drop_event
//           and drop_count update one cycle after the last flit is accepted.
// Backpressure: ring0_in_ready is registered and drops while the FIFO is full,
//           reasserting the cycle after a pop; the drop sink never stalls.
//
// Flit encoding on all ring ports (18 bits): [17] valid, [16] last, [15:0] data.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ring0_in/_ready   flit from chain end of ring 0 and its accept
//   ring1_in/_ready   flit from chain end of ring 1 and its accept
//   ring0_out/_ready  chain start of ring 0 (constant idle, ready ignored)
//   ring1_out/_ready  chain start of ring 1 (turnaround traffic) and its accept
//   drop_count        saturating count of dropped ring-1 packets
//   drop_dest         data[9:0] of the first flit of the last dropped packet
//   drop_event        one-cycle pulse per dropped packet
module debug_ring_terminator #(
  parameter int BUFFER_SIZE = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [17:0]          ring0_in,
  output logic                 ring0_in_ready,
  input  logic [17:0]          ring1_in,
  output logic                 ring1_in_ready,
  output logic [17:0]          ring0_out,
  input  logic                 ring0_out_ready,
  output logic [17:0]          ring1_out,
  input  logic                 ring1_out_ready,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic [9:0]           drop_dest,
  output logic                 drop_event
);

  localparam int PW = $clog2(BUFFER_SIZE);
  localparam int CW = $clog2(BUFFER_SIZE + 1);

  // ---------------------------------------------------------------------------
  // Turnaround FIFO: ring0_in -> ring1_out
  // ---------------------------------------------------------------------------
  logic [16:0]   mem [BUFFER_SIZE];   // {last, data}; valid is implied by count
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push;
  logic          pop;

  assign push = ring0_in[17] & ring0_in_ready;
  assign pop  = (count != '0) & ring1_out_ready;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      ring0_in_ready <= 1'b0;
    end else begin
      count <= count_next;
      // Ready looks at the post-update occupancy, so a pop while full only
      // reopens the input on the following cycle.
      ring0_in_ready <= (count_next < CW'(BUFFER_SIZE));
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(BUFFER_SIZE - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(BUFFER_SIZE - 1)) ? '0 : rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: nothing is presented while count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ring0_in[16:0];
    end
  end

  assign ring1_out = {(count != '0), mem[rd_ptr]};
  assign ring0_out = '0;

  // ---------------------------------------------------------------------------
  // Drop sink: ring1_in
  // ---------------------------------------------------------------------------
  typedef enum logic {
    IDLE,
    IN_PKT
  } state_t;

  state_t state;
  state_t state_next;
  logic   accept;
  logic   count_step;
  logic   dest_load;

  assign accept = ring1_in[17] & ring1_in_ready;

  always_comb begin
    state_next = state;
    count_step = 1'b0;
    dest_load  = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          dest_load = 1'b1;
          if (ring1_in[16]) begin
            count_step = 1'b1;
          end else begin
            state_next = IN_PKT;
          end
        end
        IN_PKT: begin
          if (ring1_in[16]) begin
            count_step = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ring1_in_ready <= 1'b0;
      drop_count     <= '0;
      drop_dest      <= '0;
      drop_event     <= 1'b0;
    end else begin
      state          <= state_next;
      ring1_in_ready <= 1'b1;
      drop_event     <= count_step;
      if (dest_load) begin
        drop_dest <= ring1_in[9:0];
      end
      if (count_step && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  // Inputs that carry no information for this block.
  logic unused_bits;
  assign unused_bits = ^{ring0_out_ready, ring1_in[15:10]};

endmodule

// File: tb/tb_debug_ring_terminator.sv
module tb_debug_ring_terminator;

  logic        clk;
  logic        rst;
  logic [17:0] ring0_in;
  logic        ring0_in_ready;
  logic [17:0] ring1_in;
  logic        ring1_in_ready;
  logic [17:0] ring0_out;
  logic        ring0_out_ready;
  logic [17:0] ring1_out;
  logic        ring1_out_ready;
  logic [3:0]  drop_count;
  logic [9:0]  drop_dest;
  logic        drop_event;

  debug_ring_terminator #(.BUFFER_SIZE(4), .CNT_WIDTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .ring0_in        (ring0_in),
    .ring0_in_ready  (ring0_in_ready),
    .ring1_in        (ring1_in),
    .ring1_in_ready  (ring1_in_ready),
    .ring0_out       (ring0_out),
    .ring0_out_ready (ring0_out_ready),
    .ring1_out       (ring1_out),
    .ring1_out_ready (ring1_out_ready),
    .drop_count      (drop_count),
    .drop_dest       (drop_dest),
    .drop_event      (drop_event)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks = 0;
  int          passed = 0;
  int          nlast  = 0;
  int          nxt    = 0;
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];

  function automatic logic [17:0] mk(input logic [15:0] d, input logic l);
    return {1'b1, l, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // Scoreboards the handshakes of the current cycle, then advances one clock
  // and leaves time 1 unit past the edge for sampling and driving.
  task automatic tick();
    if (ring1_out[17] === 1'b1 && ring1_out_ready) begin
      got_q.push_back(ring1_out);
      if (exp_q.size() == 0) chk("fifo_underflow", 32'd1, 32'd0);
      else                   chk("fifo_order", 32'(ring1_out), 32'(exp_q.pop_front()));
    end
    if (ring0_in[17] && ring0_in_ready === 1'b1) exp_q.push_back(ring0_in);
    if (ring1_in[17] && ring1_in[16] && ring1_in_ready === 1'b1) nlast++;
    chk("ring0_out_idle", 32'(ring0_out), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    ring0_in = mk(16'h5555, 1'b0);
    ring1_in = '0;
    ring0_out_ready = 1'b0;
    ring1_out_ready = 1'b0;
    tick();
    repeat (3) begin
      chk("rst_ring0_in_ready", 32'(ring0_in_ready), 32'd0);
      chk("rst_ring1_in_ready", 32'(ring1_in_ready), 32'd0);
      chk("rst_ring1_out_vld", 32'(ring1_out[17]), 32'd0);
      chk("rst_drop_count", 32'(drop_count), 32'd0);
      chk("rst_drop_dest", 32'(drop_dest), 32'd0);
      chk("rst_drop_event", 32'(drop_event), 32'd0);
      tick();
    end
    rst = 1'b0;
    tick();
    ring0_in = '0;
    chk("rel_ring0_in_ready", 32'(ring0_in_ready), 32'd1);
    chk("rel_ring1_in_ready", 32'(ring1_in_ready), 32'd1);
    chk("rel_ring1_out_vld", 32'(ring1_out[17]), 32'd0);

    // ---------------- turnaround flow ----------------
    ring1_out_ready = 1'b1;
    ring0_in = mk(16'h0012, 1'b0);
    tick();
    chk("turn_f1", 32'(ring1_out), 32'(mk(16'h0012, 1'b0)));
    ring0_in = mk(16'hA001, 1'b0);
    tick();
    chk("turn_f2", 32'(ring1_out), 32'(mk(16'hA001, 1'b0)));
    ring0_in = mk(16'hB002, 1'b1);
    tick();
    chk("turn_f3", 32'(ring1_out), 32'(mk(16'hB002, 1'b1)));
    ring0_in = '0;
    tick();
    chk("turn_empty", 32'(ring1_out[17]), 32'd0);

    // ---------------- fill and release ----------------
    got_q.delete();
    ring1_out_ready = 1'b0;
    nxt = 0;
    repeat (6) begin
      ring0_in = mk(16'(16'h1001 + nxt), nxt == 5);
      if (ring0_in_ready) nxt++;
      tick();
    end
    chk("fill_accepted", 32'(nxt), 32'd4);
    chk("fill_full_ready", 32'(ring0_in_ready), 32'd0);
    chk("fill_head", 32'(ring1_out), 32'(mk(16'h1001, 1'b0)));
    ring1_out_ready = 1'b1;
    tick();
    ring1_out_ready = 1'b0;
    chk("fill_ready_back", 32'(ring0_in_ready), 32'd1);
    chk("fill_head2", 32'(ring1_out), 32'(mk(16'h1002, 1'b0)));
    ring1_out_ready = 1'b1;
    for (int c = 0; c < 30 && got_q.size() < 6; c++) begin
      if (nxt < 6) ring0_in = mk(16'(16'h1001 + nxt), nxt == 5);
      else         ring0_in = '0;
      if (nxt < 6 && ring0_in_ready) nxt++;
      tick();
    end
    ring0_in = '0;
    chk("fill_out_count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < got_q.size(); i++) begin
      chk("fill_out_flit", 32'(got_q[i]), 32'(mk(16'(16'h1001 + i), i == 5)));
    end

    // ---------------- drop counting ----------------
    ring1_in = mk(16'h0155, 1'b0);
    tick();
    chk("drop_dest_first", 32'(drop_dest), 32'h155);
    chk("drop_event_mid", 32'(drop_event), 32'd0);
    ring1_in = mk(16'hFFFF, 1'b1);
    tick();
    ring1_in = mk(16'h0203, 1'b1);
    chk("drop_count_1", 32'(drop_count), 32'd1);
    chk("drop_event_1", 32'(drop_event), 32'd1);
    chk("drop_dest_kept", 32'(drop_dest), 32'h155);
    tick();
    ring1_in = '0;
    chk("drop_count_2", 32'(drop_count), 32'd2);
    chk("drop_event_2", 32'(drop_event), 32'd1);
    chk("drop_dest_2", 32'(drop_dest), 32'h203);
    tick();
    chk("drop_event_off", 32'(drop_event), 32'd0);

    // ---------------- saturation ----------------
    repeat (17) begin
      ring1_in = mk(16'h0300, 1'b1);
      tick();
    end
    ring1_in = '0;
    tick();
    chk("sat_count", 32'(drop_count), 32'd15);
    chk("sat_dest", 32'(drop_dest), 32'h300);

    // ---------------- mid-packet reset ----------------
    ring1_in = mk(16'h0077, 1'b0);
    tick();
    chk("mid_dest", 32'(drop_dest), 32'h077);
    rst = 1'b1;
    ring1_in = '0;
    tick();
    chk("mid_rst_count", 32'(drop_count), 32'd0);
    rst = 1'b0;
    tick();
    chk("mid_ready", 32'(ring1_in_ready), 32'd1);
    ring1_in = mk(16'h0088, 1'b1);
    tick();
    ring1_in = '0;
    chk("mid_count", 32'(drop_count), 32'd1);
    chk("mid_dest2", 32'(drop_dest), 32'h088);
    chk("mid_event", 32'(drop_event), 32'd1);

    // ---------------- concurrency ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    exp_q.delete();
    nlast = 0;
    for (int c = 0; c < 10000; c++) begin
      ring0_in        = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom)};
      ring1_out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0)
        ring1_in = {1'b1, 1'($urandom_range(0, 1)), 16'($urandom)};
      else
        ring1_in = '0;
      tick();
      chk("conc_drop_count", 32'(drop_count), 32'((nlast > 15) ? 15 : nlast));
    end
    ring0_in = '0;
    ring1_in = '0;
    ring1_out_ready = 1'b1;
    repeat (8) tick();
    chk("conc_fifo_drained", 32'(exp_q.size()), 32'd0);
    chk("conc_out_idle", 32'(ring1_out[17]), 32'd0);
    chk("conc_final_count", 32'(drop_count), 32'((nlast > 15) ? 15 : nlast));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
